// File: rtl/instruction_encoder_pkg.sv
// rtl/instruction_encoder_pkg.sv - shared types for the instruction encoder
`include "opcodes.v"

package instruction_encoder_pkg;

    localparam int WORD_W = `WORD_SIZE;

    typedef enum logic [1:0] {
        FMT_R_E        = `FMT_R,
        FMT_I_SIGNED_E = `FMT_I_SIGNED,
        FMT_I_ZERO_E   = `FMT_I_ZERO,
        FMT_J_E        = `FMT_J
    } fmt_e;

    typedef struct packed {
        logic [WORD_W-1:0] instr;
        logic              range_err;
    } fifo_entry_t;

endpackage

// File: rtl/instruction_encoder_packer.sv
// rtl/instruction_encoder_packer.sv - combinational field packing and range check
`include "opcodes.v"

module instr_packer
    import instruction_encoder_pkg::*;
(
    input  logic [1:0]        fmt,
    input  logic [3:0]        opcode,
    input  logic [1:0]        rs,
    input  logic [1:0]        rt,
    input  logic [1:0]        rd,
    input  logic [5:0]        func,
    input  logic [WORD_W-1:0] value,
    output fifo_entry_t       entry
);

    always_comb begin
        entry = '0;
        case (fmt_e'(fmt))
            FMT_R_E: begin
                entry.instr = {opcode, rs, rt, rd, func};
            end
            FMT_I_SIGNED_E: begin
                entry.instr     = {opcode, rs, rt, value[7:0]};
                // Sign-extending the low byte must reproduce the full value.
                entry.range_err = !((value[15:7] == '0) || (&value[15:7]));
            end
            FMT_I_ZERO_E: begin
                entry.instr     = {opcode, rs, rt, value[7:0]};
                entry.range_err = (value[15:8] != '0);
            end
            default: begin
                entry.instr     = {opcode, value[11:0]};
                entry.range_err = (value[15:12] != '0);
            end
        endcase
    end

endmodule

// File: rtl/opcodes.v
// rtl/opcodes.v - shared instruction word width and format encodings
`ifndef OPCODES_V
`define OPCODES_V
`define WORD_SIZE    16
`define FMT_R        2'd0
`define FMT_I_SIGNED 2'd1
`define FMT_I_ZERO   2'd2
`define FMT_J        2'd3
`endif

// File: rtl/instruction_encoder.sv
// rtl/instruction_encoder.sv - encodes field bundles into a 2-entry output FIFO
`include "opcodes.v"

module instruction_encoder
    import instruction_encoder_pkg::*;
#(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           fmt,
    input  logic [3:0]           opcode,
    input  logic [1:0]           rs,
    input  logic [1:0]           rt,
    input  logic [1:0]           rd,
    input  logic [5:0]           func,
    input  logic [`WORD_SIZE-1:0] value,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [`WORD_SIZE-1:0] instr,
    output logic                 range_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    fifo_entry_t          packed_entry;
    fifo_entry_t          mem_q [2];
    fifo_entry_t          mem_d [2];
    logic                 wr_ptr_q, wr_ptr_d;
    logic                 rd_ptr_q, rd_ptr_d;
    logic [1:0]           count_q, count_d;
    logic [ERR_CNT_W-1:0] err_count_q, err_count_d;
    logic                 push, pop;

    instr_packer u_packer (
        .fmt    (fmt),
        .opcode (opcode),
        .rs     (rs),
        .rt     (rt),
        .rd     (rd),
        .func   (func),
        .value  (value),
        .entry  (packed_entry)
    );

    assign in_ready  = (count_q < 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign instr     = mem_q[rd_ptr_q].instr;
    assign range_err = mem_q[rd_ptr_q].range_err;
    assign err_count = err_count_q;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_comb begin
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        err_count_d = err_count_q;

        if (flush) begin
            count_d  = 2'd0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = packed_entry;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + 2'(push) - 2'(pop);
        end

        // A bundle accepted in the same cycle as a flush is still counted.
        if (push && packed_entry.range_err && !(&err_count_q)) begin
            err_count_d = err_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_q[0]    <= '0;
            mem_q[1]    <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
            err_count_q <= '0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            err_count_q <= err_count_d;
        end
    end

endmodule
